// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the cache arbiter slice.
package cache_arb_types;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    // Which cache owns, or last owned, the memory port.
    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Line-granular physical-memory bus. The requester (cache) side uses the
// master modport; the responder (memory or arbiter front) side uses slave.
interface cache_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_arbiter_pick.sv
// Combinational winner selection between I-cache and D-cache requests.
// Build option: define CACHE_ARB_RR_EN for round-robin on ties; otherwise
// the D-cache wins every tie and last_grant is ignored.
module cache_arb_pick
    import cache_arb_types::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  arb_owner_t last_grant_i,
    output arb_owner_t winner_o,
    output logic       valid_o
);

`ifdef CACHE_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    // Lone requester wins outright; a tie goes to D unless round-robin
    // says D was the last owner.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        valid_o  = i_req_i | d_req_i;
        winner_o = OWN_D;
        if (i_req_i && !d_req_i) begin
            winner_o = OWN_I;
        end else if (i_req_i && d_req_i) begin
            winner_o = (!RR_EN || last_grant_i == OWN_I) ? OWN_D : OWN_I;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one 256-bit physical-memory port between the I-cache and D-cache.
// One owner at a time; every transaction is followed by one IDLE cycle so
// a back-to-back D write-back/allocate pair re-arbitrates.
// Build option: CACHE_ARB_RR_EN selects round-robin tie-breaking.
module cache_arbiter
    import cache_arb_types::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    cache_arbiter_if.slave  i_cache,
    cache_arbiter_if.slave  d_cache,
    cache_arbiter_if.master pmem
);

    arb_state_t state_q, state_d;
    arb_owner_t last_grant_q, last_grant_d;
    arb_owner_t winner;
    logic       win_valid;
    logic       i_req, d_req;

    assign i_req = i_cache.pmem_read;
    assign d_req = d_cache.pmem_read | d_cache.pmem_write;

    cache_arb_pick u_pick (
        .i_req_i      (i_req),
        .d_req_i      (d_req),
        .last_grant_i (last_grant_q),
        .winner_o     (winner),
        .valid_o      (win_valid)
    );

    // State and last-grant registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic and owner routing; all outputs are 0 in IDLE.
    always_comb begin
        state_d              = state_q;
        last_grant_d         = last_grant_q;
        pmem.pmem_read       = 1'b0;
        pmem.pmem_write      = 1'b0;
        pmem.pmem_address    = {ADDR_W{1'b0}};
        pmem.pmem_wdata      = {LINE_W{1'b0}};
        i_cache.pmem_resp    = 1'b0;
        d_cache.pmem_resp    = 1'b0;
        i_cache.pmem_rdata   = {LINE_W{1'b0}};
        d_cache.pmem_rdata   = {LINE_W{1'b0}};

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = (winner == OWN_I) ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I: begin
                pmem.pmem_read     = i_cache.pmem_read;
                pmem.pmem_address  = i_cache.pmem_address;
                i_cache.pmem_resp  = pmem.pmem_resp;
                i_cache.pmem_rdata = pmem.pmem_rdata;
                d_cache.pmem_rdata = pmem.pmem_rdata;
                if (pmem.pmem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = OWN_I;
                end else if (!i_req) begin
                    // Owner abandoned the request: release without credit.
                    state_d = IDLE;
                end
            end
            SERVE_D: begin
                // Read+write together is illegal; the write-back wins.
                pmem.pmem_write    = d_cache.pmem_write;
                pmem.pmem_read     = d_cache.pmem_read & ~d_cache.pmem_write;
                pmem.pmem_address  = d_cache.pmem_address;
                pmem.pmem_wdata    = d_cache.pmem_wdata;
                d_cache.pmem_resp  = pmem.pmem_resp;
                i_cache.pmem_rdata = pmem.pmem_rdata;
                d_cache.pmem_rdata = pmem.pmem_rdata;
                if (pmem.pmem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = OWN_D;
                end else if (!d_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Protocol invariants on the shared port and the response fan-out.
    assert property (@(posedge clk) disable iff (rst)
        !(pmem.pmem_read && pmem.pmem_write));
    assert property (@(posedge clk) disable iff (rst)
        !(i_cache.pmem_resp && d_cache.pmem_resp));

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_cache_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) i_bus ();
    cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) d_bus ();
    cache_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) m_bus ();

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_cache (i_bus.slave),
        .d_cache (d_bus.slave),
        .pmem    (m_bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [LINE_W-1:0] DATA_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] DATA_5A = {32{8'h5A}};

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_bus.pmem_read    = 1'b0;
        i_bus.pmem_write   = 1'b0;
        i_bus.pmem_address = '0;
        i_bus.pmem_wdata   = '0;
        d_bus.pmem_read    = 1'b0;
        d_bus.pmem_write   = 1'b0;
        d_bus.pmem_address = '0;
        d_bus.pmem_wdata   = '0;
        m_bus.pmem_resp    = 1'b0;
        m_bus.pmem_rdata   = DATA_A5;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Every output of the arbiter must read 0.
    task automatic chk_idle(input string tag);
        check({tag, ".rd"},    m_bus.pmem_read,    0);
        check({tag, ".wr"},    m_bus.pmem_write,   0);
        check({tag, ".addr"},  m_bus.pmem_address, 0);
        check({tag, ".wdata"}, m_bus.pmem_wdata,   0);
        check({tag, ".iresp"}, i_bus.pmem_resp,    0);
        check({tag, ".dresp"}, d_bus.pmem_resp,    0);
        check({tag, ".irdat"}, i_bus.pmem_rdata,   0);
        check({tag, ".drdat"}, d_bus.pmem_rdata,   0);
    endtask

    task automatic chk_mem(input string tag, input logic rd, input logic wr,
                           input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wdata);
        check({tag, ".rd"},    m_bus.pmem_read,    rd);
        check({tag, ".wr"},    m_bus.pmem_write,   wr);
        check({tag, ".addr"},  m_bus.pmem_address, addr);
        check({tag, ".wdata"}, m_bus.pmem_wdata,   wdata);
    endtask

    // Pulse memory resp for one cycle and check which cache sees it.
    task automatic respond(input string tag, input logic to_d);
        m_bus.pmem_resp = 1'b1;
        #1;
        check({tag, ".iresp"}, i_bus.pmem_resp, !to_d);
        check({tag, ".dresp"}, d_bus.pmem_resp, to_d);
        if (to_d) check({tag, ".drdat"}, d_bus.pmem_rdata, DATA_A5);
        else      check({tag, ".irdat"}, i_bus.pmem_rdata, DATA_A5);
        tick();
        m_bus.pmem_resp = 1'b0;
    endtask

    logic exp_d [3];

    initial begin
        clear_inputs();
        do_reset();
        chk_idle("reset");

        // 1: lone I read, memory answers after 5 cycles.
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_1000;
        #1;
        check("t1.latency", m_bus.pmem_read, 1'b0);
        tick();
        chk_mem("t1.grant", 1'b1, 1'b0, 32'h0000_1000, '0);
        for (int c = 0; c < 4; c++) begin
            check("t1.noresp", i_bus.pmem_resp, 1'b0);
            tick();
            check("t1.hold", m_bus.pmem_read, 1'b1);
        end
        respond("t1.resp", 1'b0);
        i_bus.pmem_read = 1'b0;
        #1;
        chk_idle("t1.bubble");

        // 2: D write-back then allocate read after one IDLE cycle.
        d_bus.pmem_write   = 1'b1;
        d_bus.pmem_address = 32'h0000_2000;
        d_bus.pmem_wdata   = DATA_5A;
        tick();
        chk_mem("t2.wb", 1'b0, 1'b1, 32'h0000_2000, DATA_5A);
        respond("t2.wbresp", 1'b1);
        d_bus.pmem_write   = 1'b0;
        d_bus.pmem_read    = 1'b1;
        d_bus.pmem_address = 32'h0000_3000;
        d_bus.pmem_wdata   = '0;
        #1;
        chk_idle("t2.bubble");
        tick();
        chk_mem("t2.alloc", 1'b1, 1'b0, 32'h0000_3000, '0);
        respond("t2.allocresp", 1'b1);
        d_bus.pmem_read = 1'b0;
        #1;
        chk_idle("t2.end");

        // 3: simultaneous requests from reset; D first, then I.
        do_reset();
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_1100;
        d_bus.pmem_read    = 1'b1;
        d_bus.pmem_address = 32'h0000_2200;
        tick();
        chk_mem("t3.first", 1'b1, 1'b0, 32'h0000_2200, '0);
        respond("t3.dresp", 1'b1);
        d_bus.pmem_read = 1'b0;
        #1;
        chk_idle("t3.bubble");
        tick();
        chk_mem("t3.second", 1'b1, 1'b0, 32'h0000_1100, '0);
        respond("t3.iresp", 1'b0);
        i_bus.pmem_read = 1'b0;

        // 4: D requests continuously, I once.
        do_reset();
`ifdef CACHE_ARB_RR_EN
        exp_d = '{1'b1, 1'b0, 1'b1};
`else
        exp_d = '{1'b1, 1'b1, 1'b1};
`endif
        d_bus.pmem_read    = 1'b1;
        d_bus.pmem_address = 32'h0000_4000;
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_1400;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_mem($sformatf("t4.g%0d", k), 1'b1, 1'b0,
                    exp_d[k] ? 32'h0000_4000 : 32'h0000_1400, '0);
            respond($sformatf("t4.r%0d", k), exp_d[k]);
            if (!exp_d[k]) i_bus.pmem_read = 1'b0;
            if (k == 2)    d_bus.pmem_read = 1'b0;
            #1;
            check($sformatf("t4.bub%0d", k), m_bus.pmem_read, 1'b0);
        end
        tick();
`ifdef CACHE_ARB_RR_EN
        chk_idle("t4.done");
`else
        chk_mem("t4.late_i", 1'b1, 1'b0, 32'h0000_1400, '0);
        respond("t4.late_iresp", 1'b0);
        i_bus.pmem_read = 1'b0;
`endif

        // 5: reset two cycles into SERVE_D with I pending.
        do_reset();
        d_bus.pmem_write   = 1'b1;
        d_bus.pmem_address = 32'h0000_5000;
        d_bus.pmem_wdata   = DATA_5A;
        tick();
        chk_mem("t5.wb", 1'b0, 1'b1, 32'h0000_5000, DATA_5A);
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_1500;
        tick();
        rst = 1'b1;
        tick();
        chk_idle("t5.abort");
        rst = 1'b0;
        d_bus.pmem_write = 1'b0;
        d_bus.pmem_wdata = '0;
        tick();
        chk_mem("t5.igrant", 1'b1, 1'b0, 32'h0000_1500, '0);
        respond("t5.iresp", 1'b0);
        i_bus.pmem_read = 1'b0;

        // 6: owner I drops its request; pending D is granted next.
        do_reset();
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_1600;
        tick();
        chk_mem("t6.igrant", 1'b1, 1'b0, 32'h0000_1600, '0);
        d_bus.pmem_read    = 1'b1;
        d_bus.pmem_address = 32'h0000_6000;
        tick();
        chk_mem("t6.ihold", 1'b1, 1'b0, 32'h0000_1600, '0);
        i_bus.pmem_read = 1'b0;
        #1;
        check("t6.drop_rd", m_bus.pmem_read, 1'b0);
        check("t6.drop_iresp", i_bus.pmem_resp, 1'b0);
        tick();
        chk_idle("t6.idle");
        tick();
        chk_mem("t6.dgrant", 1'b1, 1'b0, 32'h0000_6000, '0);
        respond("t6.dresp", 1'b1);
        d_bus.pmem_read = 1'b0;

        // 7: illegal D read+write together: write wins.
        d_bus.pmem_read    = 1'b1;
        d_bus.pmem_write   = 1'b1;
        d_bus.pmem_address = 32'h0000_7000;
        d_bus.pmem_wdata   = DATA_5A;
        tick();
        chk_mem("t7.both", 1'b0, 1'b1, 32'h0000_7000, DATA_5A);
        respond("t7.resp", 1'b1);
        clear_inputs();
        #1;
        chk_idle("t7.end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
